// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone arbiter types and bus constants
package wb_pkg;

  localparam int WB_DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/wb_outst_cnt.sv
// rtl/wb_outst_cnt.sv - saturating outstanding-request counter with full/zero flags
module wb_outst_cnt #(
  parameter int MAX   = 4,
  parameter int CNT_W = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic zero_o
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;

  // Simultaneous inc and dec cancel; both ends hold instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !dec_i && count_q != MAX_C) begin
      count_d = count_q + ONE_C;
    end else if (dec_i && !inc_i && count_q != '0) begin
      count_d = count_q - ONE_C;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign full_o = (count_q == MAX_C);
  assign zero_o = (count_q == '0);

endmodule

// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master round-robin arbiter for a pipelined Wishbone slave
module wb_arbiter2
  import wb_pkg::*;
#(
  parameter int  MAX_OUTST = 4,
  parameter int  ADR_W     = 16,
  localparam int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [WB_DW-1:0] m0_dat_i,
  input  logic             m0_we_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  output logic [WB_DW-1:0] m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_stall_o,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [WB_DW-1:0] m1_dat_i,
  input  logic             m1_we_i,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  output logic [WB_DW-1:0] m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_stall_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [WB_DW-1:0] s_dat_o,
  output logic             s_we_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  input  logic [WB_DW-1:0] s_dat_i,
  input  logic             s_ack_i,
  input  logic             s_stall_i,
  output logic [1:0]       owner_o,
  output logic             err_o
);

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic       err_q, err_d;
  logic       full, zero;
  logic       owner_cyc, release_arb, accept, fwd_ack;

  assign owner_cyc   = (state_q == G0 && m0_cyc_i) || (state_q == G1 && m1_cyc_i);
  assign release_arb = (state_q != IDLE) && !owner_cyc;
  assign accept      = s_stb_o && !s_stall_i;
  // An ack with nothing outstanding belongs to an aborted cycle and is swallowed.
  assign fwd_ack     = s_ack_i && !zero && (state_q != IDLE);
  assign err_d       = err_q || (s_ack_i && zero);

  // last_q: 0 = m0 won most recently, 1 = m1.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
          state_d = G0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = G1;
          last_d  = 1'b1;
        end
      end
      G0: begin
        if (!m0_cyc_i) begin
          state_d = m1_cyc_i ? G1 : IDLE;
          if (m1_cyc_i) last_d = 1'b1;
        end
      end
      G1: begin
        if (!m1_cyc_i) begin
          state_d = m0_cyc_i ? G0 : IDLE;
          if (m0_cyc_i) last_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_adr_o    = '0;
    s_dat_o    = '0;
    s_we_o     = 1'b0;
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    m0_dat_o   = '0;
    m0_ack_o   = 1'b0;
    m0_stall_o = 1'b1;
    m1_dat_o   = '0;
    m1_ack_o   = 1'b0;
    m1_stall_o = 1'b1;
    unique case (state_q)
      G0: begin
        s_adr_o    = m0_adr_i;
        s_dat_o    = m0_dat_i;
        s_we_o     = m0_we_i;
        s_cyc_o    = m0_cyc_i;
        s_stb_o    = m0_stb_i && !full;
        m0_dat_o   = s_dat_i;
        m0_ack_o   = fwd_ack;
        m0_stall_o = s_stall_i || full;
      end
      G1: begin
        s_adr_o    = m1_adr_i;
        s_dat_o    = m1_dat_i;
        s_we_o     = m1_we_i;
        s_cyc_o    = m1_cyc_i;
        s_stb_o    = m1_stb_i && !full;
        m1_dat_o   = s_dat_i;
        m1_ack_o   = fwd_ack;
        m1_stall_o = s_stall_i || full;
      end
      default: ;
    endcase
  end

  wb_outst_cnt #(
    .MAX   (MAX_OUTST),
    .CNT_W (CNT_W)
  ) u_outst_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (release_arb),
    .inc_i   (accept),
    .dec_i   (fwd_ack),
    .full_o  (full),
    .zero_o  (zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign owner_o = {state_q == G1, state_q == G0};
  assign err_o   = err_q;

endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master, one-slave Wishbone arbiter for the classic pipelined bus.
- Lets the CPU (m0) and the USB debug/bridge master (m1) share the board I/O slave and other single-port 16-bit peripherals.
- Grants are round-robin and per bus cycle (held while the owner keeps cyc high).
- Tracks outstanding requests so acknowledges are returned only to the master that issued them.

Parameters:
- MAX_OUTST, 4, maximum accepted-but-unacknowledged requests per grant (range 1..15).
- CNT_W, $clog2(MAX_OUTST+1), outstanding counter width (derived; do not override).

Ports:
- clk  input  1  bus clock; all state on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- m0  if_wb.slave  -  master port 0 (CPU); wins the first arbitration after reset.
- m1  if_wb.slave  -  master port 1 (USB bridge).
- s  if_wb.master  -  shared slave port (adr, dat, we, cyc, stb in; dat, ack, stall back).
- owner  output  2  one-hot current grant (01=m0, 10=m1, 00=idle), for debug LEDs.
- err  output  1  sticky flag: slave ack received while outstanding count == 0; cleared only by reset.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, count=0, last=m1, err=0, owner=00.
  - s.cyc=s.stb=0.
  - m0/m1 ack=0 and stall=1.
- States:
  - IDLE: no grant.
  - G0: m0 owns the slave.
  - G1: m1 owns the slave.
- IDLE → Gx (registered, one cycle of arbitration latency):
  - Only one cyc high → grant that master.
  - Both high → grant the master that is not `last`.
  - Set last = winner.
- Gx → release, when owner cyc is low:
  - Other master's cyc high → hand over directly to it (G0→G1 or G1→G0); update last; count=0.
  - Otherwise → IDLE.
  - No idle cycle on handover.
- Muxing in Gx (combinational):
  - s.adr/s.dat/s.we/s.cyc come from the owner.
  - s.stb = owner.stb & ~full.
  - Owner ack = s.ack; owner dat = s.dat.
  - Owner stall = s.stall | full.
- Non-owner: ack=0, stall=1, dat=0.
- IDLE: s.cyc=s.stb=0; both masters see stall=1.
- full = (count == MAX_OUTST).
- Accept = s.stb & ~s.stall.
- Counter update in Gx:
  - +1 on accept.
  - −1 on s.ack.
  - Accept and ack in the same cycle → unchanged.
  - Saturates at MAX_OUTST via the stall; never wraps.
- s.ack with count==0:
  - Set err.
  - Ack is not forwarded to either master.
- Owner drops cyc while count>0: abort per Wishbone.
  - count cleared on release.
  - Late s.ack in the following state is dropped and sets err only if count==0 in that state.
- Throughput: with s.stall=0 and s.ack one cycle after stb (board I/O timing), the owner sustains one transfer per cycle.
- Reset asserted mid-cycle: immediate return to reset values. In-flight transfers are discarded without a response.

Decomposition:
- Shared package wb_pkg holds:
  - typedef enum logic [1:0] {IDLE, G0, G1} arb_state_t;
  - the 16-bit data-width constant shared with if_wb users.
- Natural sub-module: wb_outst_cnt (up/down saturating counter with full and zero flags), so it can be reused by a future N-master arbiter.

Test Plan:
- Reset, then m0 alone: cyc/stb, we=1, adr=LEDG word, dat=16'h00A5 → owner=01 one cycle after cyc. s.stb sees the write next cycle. m0 gets ack one cycle later. m1 stall=1 throughout.
- Both raise cyc in the same cycle after reset → m0 granted first. When m0 drops cyc with m1 still high, owner goes 01→10 with no IDLE cycle. Next simultaneous request → m0 granted (round-robin).
- m1 issues 6 back-to-back reads of SW with s.ack delayed by 4 cycles and MAX_OUTST=4 → m1 stall=1 after the 4th accept. Each ack decrements count. All 6 reads return sw=10'h2A5, in order, to m1 only.
- Owner cyc drops with count=2, then s.ack pulses twice → acks not forwarded; count already 0, so err=1. A second reset clears err.
- Simultaneous accept and ack for 20 cycles at full rate → count stays constant and ledr updates every cycle without stall.
- reset_n pulsed low asynchronously mid-burst (between clock edges) → s.cyc=0, owner=00, and both stalls=1 before the next clk edge; the first request after release is granted to m0.
